instr_fetch: RTL and testbench



---
 rtl/rv_fetch_pkg.sv | 19 +
 rtl/instr_fetch_if.sv | 10 +
 rtl/fetch_fifo.sv | 40 ++++
 rtl/instr_fetch.sv | 80 ++++++++
 tb/tb_instr_fetch.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared fetch-stage constants, fetch state encoding and opcode groups used by decode
package rv_fetch_pkg;
   localparam int XLEN_DEFAULT = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic {RUN, HALT} fetch_state_e;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   function automatic logic [6:0] opcode_of(input logic [31:0] i);
      return i[6:0];
   endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory request/response bus between the fetch stage and imem
interface instr_fetch_if import rv_fetch_pkg::*; #(parameter int XLEN = XLEN_DEFAULT);
   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [31:0]     rdata;
   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer with synchronous flush, occupancy count and register-backed head
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WIDTH-1:0]             data_i,
   output logic [WIDTH-1:0]             head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [CW-1:0]    count_q;
   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
   endfunction
   // Flush beats push/pop; the storage array itself needs no reset
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= inc(wr_q);
         end
         if (pop_i) rd_q <= inc(rd_q);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end
   assign head_o  = mem_q[rd_q];
   assign count_o = count_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage with credit-limited imem requests, response FIFO and redirect flush; FETCH_ALIGN_CHECK_EN adds misaligned-redirect fault and HALT
module instr_fetch import rv_fetch_pkg::*; #(
   parameter int              XLEN       = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   instr_fetch_if.master   imem,
   output logic            instr_valid_o,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   input  logic            instr_ready_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            fetch_fault_o
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
   logic [CW-1:0]   out_q, out_d, drop_q, drop_d, count;
   logic [XLEN+31:0] head;
   logic            run, fire, rsp, push, pop;
   assign imem.req  = run && !rst && !redirect_valid_i &&
                      ({1'b0, out_q} + {1'b0, count} < (CW+1)'(FIFO_DEPTH));
   assign imem.addr = fetch_pc_q;
   assign fire      = imem.req && imem.gnt;
   assign rsp       = imem.rvalid && out_q != '0;
   assign push      = rsp && drop_q == '0 && !redirect_valid_i;
   assign pop       = instr_valid_o && instr_ready_i && !redirect_valid_i;
   // Next PCs and credit counters; a redirect re-bases both PCs and marks every in-flight response stale
   always_comb begin
      out_d      = out_q + CW'(fire) - CW'(rsp);
      drop_d     = redirect_valid_i ? out_d : (rsp && drop_q != '0) ? drop_q - 1'b1 : drop_q;
      fetch_pc_d = redirect_valid_i ? target : fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
      resp_pc_d  = redirect_valid_i ? target : push ? resp_pc_q + XLEN'(4) : resp_pc_q;
   end
   // PC and credit registers
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end
`ifdef FETCH_ALIGN_CHECK_EN
   fetch_state_e state_q;
   logic         fault_q, misaligned;
   assign misaligned = redirect_valid_i && redirect_pc_i[1:0] != 2'b00;
   assign target     = redirect_pc_i;
   // A misaligned redirect halts fetch and pulses the fault; an aligned one resumes
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         fault_q <= 1'b0;
      end else begin
         fault_q <= misaligned;
         if (redirect_valid_i) state_q <= misaligned ? HALT : RUN;
      end
   end
   assign run           = state_q == RUN;
   assign fetch_fault_o = fault_q;
`else
   assign target        = redirect_pc_i & ~XLEN'(3);
   assign run           = 1'b1;
   assign fetch_fault_o = 1'b0;
`endif
   fetch_fifo #(.WIDTH(XLEN + 32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .flush_i(redirect_valid_i), .push_i(push), .pop_i(pop),
      .data_i({resp_pc_q, imem.rdata}), .head_o(head), .count_o(count)
   );
   assign instr_valid_o = count != '0;
   assign instr_o       = instr_valid_o ? head[31:0] : NOP_INSTR;
   assign instr_pc_o    = instr_valid_o ? head[XLEN+31:32] : '0;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against an instruction-stream model
module tb_instr_fetch;
   import rv_fetch_pkg::*;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid, instr_ready, redirect_valid, fetch_fault;
   logic [31:0] instr, instr_pc, redirect_pc;
   int          checks = 0, failures = 0;
   instr_fetch_if #(.XLEN(32)) imem ();
   instr_fetch #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .imem(imem.master),
      .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
      .instr_ready_i(instr_ready), .redirect_valid_i(redirect_valid),
      .redirect_pc_i(redirect_pc), .fetch_fault_o(fetch_fault)
   );
   always #5 clk = ~clk;

   logic [31:0] pend[$];
   logic [31:0] popped[$];
   logic [31:0] exp_fetch = 0, exp_pc = 0;
   bit          halted = 0, exp_fault = 0;
   int          gnt_pct = 100, rv_pct = 100, cyc = 0, pops = 0, first_req = -1, first_valid = -1;

   function automatic logic [31:0] memf(input logic [31:0] pc);
      return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [31:0] tgt;
      imem.rvalid = 1'b0;
      imem.rdata  = $urandom;
      if (!rst && pend.size() > 0 && $urandom_range(99) < rv_pct) begin
         imem.rvalid = 1'b1;
         imem.rdata  = memf(pend[0]);
      end
      imem.gnt = $urandom_range(99) < gnt_pct;
      #1;
      if (rst) chk("req_in_reset", imem.req, 0);
      else begin
         chk("fault", fetch_fault, exp_fault);
         if (!instr_valid) begin
            chk("idle_instr", instr, NOP_INSTR);
            chk("idle_pc", instr_pc, 0);
         end
         if (redirect_valid || halted) chk("req_blocked", imem.req, 0);
         else if (imem.req) chk("addr", imem.addr, exp_fetch);
         if (imem.req) chk("credit", pend.size() < 2, 1);
         if (instr_valid && instr_ready && !redirect_valid) begin
            chk("pop_pc", instr_pc, exp_pc);
            chk("pop_instr", instr, memf(exp_pc));
            popped.push_back(instr_pc);
            exp_pc += 4;
            pops++;
         end
         if (first_valid < 0 && instr_valid) first_valid = cyc;
         if (first_req < 0 && imem.req) first_req = cyc;
         if (imem.req && imem.gnt) begin
            pend.push_back(imem.addr);
            exp_fetch += 4;
         end
      end
      if (imem.rvalid) void'(pend.pop_front());
      if (!rst && redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
         tgt    = redirect_pc;
         halted = redirect_pc[1:0] != 2'b00;
`else
         tgt = redirect_pc & ~32'h3;
`endif
         exp_fetch = tgt;
         exp_pc    = tgt;
      end
      @(posedge clk);
      cyc++;
      exp_fault = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      exp_fault = !rst && redirect_valid && redirect_pc[1:0] != 2'b00;
`endif
      if (rst) begin
         pend.delete();
         exp_fetch = 0;
         exp_pc    = 0;
         halted    = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      cyc = 0;
      first_req = -1;
      first_valid = -1;
      popped.delete();
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
      popped.delete();
   endtask

   initial begin
      instr_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem.gnt = 1'b0;
      imem.rvalid = 1'b0;
      imem.rdata = '0;
      // streaming from reset
      do_reset();
      #1;
      chk("rst_valid", instr_valid, 0);
      chk("rst_fault", fetch_fault, 0);
      chk("rst_req", imem.req, 1);
      chk("rst_addr", imem.addr, 32'h0);
      repeat (12) tick();
      chk("first_latency", first_valid - first_req, 2);
      chk("stream_pops", popped.size() >= 3, 1);
      if (popped.size() >= 3) begin
         chk("stream_pc1", popped[1], 32'h4);
         chk("stream_pc2", popped[2], 32'h8);
      end
      // decode back-pressure fills the buffer and stops requests
      do_reset();
      instr_ready = 1'b0;
      repeat (8) tick();
      #1;
      chk("bp_req", imem.req, 0);
      chk("bp_outstanding", pend.size(), 0);
      chk("bp_valid", instr_valid, 1);
      chk("bp_pc", instr_pc, 32'h0);
      instr_ready = 1'b1;
      repeat (20) tick();
      chk("bp_resume", popped.size() >= 5, 1);
      // grant stall holds the address
      do_reset();
      gnt_pct = 0;
      repeat (5) begin
         #1;
         chk("stall_req", imem.req, 1);
         chk("stall_addr", imem.addr, 32'h0);
         tick();
      end
      gnt_pct = 100;
      rv_pct = 0;
      tick();
      #1;
      chk("stall_next_addr", imem.addr, 32'h4);
      // redirect with two requests in flight
      do_reset();
      rv_pct = 100;
      for (int i = 0; i < 50 && !(exp_fetch == 32'h8 && pend.size() == 0); i++) tick();
      rv_pct = 0;
      for (int i = 0; i < 10 && pend.size() < 2; i++) tick();
      chk("inflight_cnt", pend.size(), 2);
      if (pend.size() == 2) begin
         chk("inflight_a0", pend[0], 32'h8);
         chk("inflight_a1", pend[1], 32'hC);
      end
      redirect(32'h100);
      rv_pct = 100;
      repeat (15) tick();
      chk("redir_pops", popped.size() > 0, 1);
      if (popped.size() > 0) chk("redir_first_pc", popped[0], 32'h100);
      // redirect coinciding with a response and a pop
      do_reset();
      instr_ready = 1'b0;
      repeat (2) tick();
      chk("coinc_pend", pend.size(), 1);
      chk("coinc_valid", instr_valid, 1);
      instr_ready = 1'b1;
      redirect(32'h300);
      #1;
      chk("coinc_flushed", instr_valid, 0);
      repeat (15) tick();
      chk("coinc_pops", popped.size() > 0, 1);
      if (popped.size() > 0) chk("coinc_first_pc", popped[0], 32'h300);
      // misaligned redirect
      do_reset();
      repeat (4) tick();
      redirect(32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
      #1;
      chk("fault_pulse", fetch_fault, 1);
      chk("halt_req", imem.req, 0);
      tick();
      #1;
      chk("fault_clear", fetch_fault, 0);
      repeat (4) tick();
      chk("halt_no_pop", popped.size(), 0);
      redirect(32'h200);
      repeat (15) tick();
      chk("resume_pops", popped.size() > 0, 1);
      if (popped.size() > 0) chk("resume_first_pc", popped[0], 32'h200);
`else
      #1;
      chk("no_fault", fetch_fault, 0);
      repeat (15) tick();
      chk("align_pops", popped.size() > 0, 1);
      if (popped.size() > 0) chk("align_first_pc", popped[0], 32'h100);
`endif
      // randomized traffic with redirects, wrap-around targets and mid-flight resets
      do_reset();
      pops = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 100 == 0) begin
            gnt_pct = $urandom_range(100, 30);
            rv_pct  = $urandom_range(100, 30);
         end
         instr_ready = $urandom_range(99) < 70;
         if ($urandom_range(199) == 0) do_reset();
         else if ($urandom_range(99) < 4) begin
            redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFC);
            if ($urandom_range(7) == 0) redirect_pc[1:0] = 2'($urandom_range(3, 1));
            redirect(redirect_pc);
         end else tick();
      end
      chk("rand_progress", pops > 200, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
